irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources; fixed at 8 in this revision.
REQ-002 SHALL have ports, one per line:
- clk  in  1  bus clock (E); all logic on its rising edge
- RESET  in  1  synchronous active-low reset
- cs  in  1  register select, decoded at $E6E0 (DS7, ADDR[4]=0)
- rw  in  1  1 = read, 0 = write
- AD  in  3  register address
- DI  in  8  write data
- DO  out  8  read data, combinational from AD
- src  in  8  asynchronous active-high interrupt requests; bit0 is the simpleio irq
- irq0_n  out  1  CPU IRQ[0], active-low, registered
- irq1_n  out  1  CPU IRQ[1], active-low, registered
- nmi_n  out  1  CPU NMI, active-low, registered

Function
REQ-003 SHALL synchronise src through a 2-flop chain to srcs; all further logic uses only srcs.
REQ-004 SHALL treat each clk edge with cs=1 as exactly one bus access; a write is cs&!rw, a read is cs&rw.
REQ-005 SHALL implement this register map:
- 0 PEND: R = pending; W = write-1-to-clear edge bits
- 1 MASK: R/W, 1 = enabled
- 2 ROUTE: R/W, 0 = IRQ0, 1 = IRQ1
- 3 EDGE: R/W, 1 = rising-edge, 0 = level
- 4 VEC0: R only, {valid, 4'b0, idx[2:0]}
- 5 VEC1: R only, same format as VEC0
- 6 RAW: R only, returns srcs
- 7 CTRL: R/W; bit0 = GEN global enable, bit1 = NMIEN; other bits read 0
REQ-006 SHALL set an edge-mode pending bit on the cycle after srcs rises (0 then 1).
REQ-007 SHALL clear an edge-mode pending bit by PEND write-1 or by a VECn read that reports it; a simultaneous set wins over clear.
REQ-008 SHALL make a level-mode pending bit equal srcs; clear actions SHALL have no effect on it.
REQ-009 SHALL clear a pending bit when EDGE changes from 1 to 0 for that bit.
REQ-010 SHALL compute VECn over pend&MASK&(ROUTE==n); lowest index has highest priority; valid=0 and idx=0 when the set is empty.
REQ-011 SHALL drive irqn_n = ~(GEN & |(pend&MASK&(ROUTE==n))), registered one clk after pend.
REQ-012 SHALL give a latency of 4 clk from a rising src edge to irqn_n low, when enabled.
REQ-013 SHALL deassert irqn_n one clk after the last qualifying pending bit clears.
REQ-014 SHALL make a MASK or GEN write take effect on irqn_n one clk after the write edge.
REQ-015 SHALL return 8'h00 on DO for undefined bits.

Reset
REQ-016 SHALL, with RESET low at a clk edge, set PEND, MASK, ROUTE, EDGE, CTRL and the synchroniser to 0 and set irq0_n, irq1_n and nmi_n to 1.
REQ-017 SHALL discard a reset asserted mid-access together with its side effects; there are no partial writes.

Configuration
REQ-018 SHALL, when IRQ_CTRL_NMI_EN is defined and NMIEN=1, force source 7 to edge mode.
REQ-019 SHALL, in that case, exclude source 7 from VEC0, VEC1 and the irq outputs.
REQ-020 SHALL, in that case, drive nmi_n low (registered) while PEND[7]=1, ignoring MASK and GEN.
REQ-021 SHALL, when IRQ_CTRL_NMI_EN is undefined, tie nmi_n to 1, make CTRL bit1 read 0 and ignore writes to it.

Structure
REQ-022 SHALL place register offsets (REG_PEND..REG_CTRL), the CTRL bit positions and the VEC valid-bit position in package irq_ctrl_pkg.
REQ-023 SHALL implement the 8-to-3 lowest-index priority encoder as sub-module irq_prio_enc, instantiated twice (VEC0, VEC1).

Verification
REQ-024 SHALL cover: EDGE=01, MASK=01, CTRL=01, src[0] pulse -> irq0_n low 4 clk later, VEC0=8'h80; reading VEC0 -> next clk PEND=00 and irq0_n high.
REQ-025 SHALL cover: MASK=FF, ROUTE=F0, EDGE=FF, GEN=1, src[5] and src[2] rise together -> VEC0=8'h82 and VEC1=8'h85; both irq0_n and irq1_n low.
REQ-026 SHALL cover: level mode on bit 3, src[3] held high, PEND write 8'h08 -> PEND[3] stays 1; src[3] low -> irq0_n high 4 clk later.
REQ-027 SHALL cover: a PEND W1C of bit1 on the same clk as a new src[1] edge -> PEND[1]=1 afterwards.
REQ-028 SHALL cover, with IRQ_CTRL_NMI_EN defined and CTRL=03: src[7] rise -> nmi_n low with VEC0 valid=0; W1C 8'h80 -> nmi_n high next clk; without the macro nmi_n stays 1 throughout.
REQ-029 SHALL cover: RESET low during a MASK write of 8'hFF -> MASK=00 and all outputs 1 after reset.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, CTRL/VEC bit
// positions and small helpers for building VEC bytes and one-hot clear masks.
package irq_ctrl_pkg;

  localparam int unsigned NSRC_FIXED = 8;

  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_MASK  = 3'd1;
  localparam logic [2:0] REG_ROUTE = 3'd2;
  localparam logic [2:0] REG_EDGE  = 3'd3;
  localparam logic [2:0] REG_VEC0  = 3'd4;
  localparam logic [2:0] REG_VEC1  = 3'd5;
  localparam logic [2:0] REG_RAW   = 3'd6;
  localparam logic [2:0] REG_CTRL  = 3'd7;

  localparam int unsigned CTRL_GEN_BIT   = 0;
  localparam int unsigned CTRL_NMIEN_BIT = 1;
  localparam int unsigned VEC_VALID_BIT  = 7;
  localparam int unsigned NMI_SRC        = 7;

  function automatic logic [7:0] vec_byte(input logic valid, input logic [2:0] idx);
    logic [7:0] v;
    v = 8'h00;
    v[VEC_VALID_BIT] = valid;
    v[2:0] = idx;
    return v;
  endfunction

  function automatic logic [7:0] idx_onehot(input logic valid, input logic [2:0] idx);
    logic [7:0] r;
    r = 8'h00;
    if (valid) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// 8-to-3 priority encoder; the lowest set request index wins.
module irq_prio_enc (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    valid = |req;
    idx   = 3'd0;
    // Scan downwards so the lowest set bit is the last (winning) assignment.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: 8 synchronised sources, edge/level pending, mask, route to
// IRQ0/IRQ1 with vector registers. Define IRQ_CTRL_NMI_EN to enable NMI on source 7.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic            cs,
  input  logic            rw,
  input  logic [2:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic [NSRC-1:0] src,
  output logic            irq0_n,
  output logic            irq1_n,
  output logic            nmi_n
);

  logic [7:0] src_meta_q, srcs_q, srcs_prev_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, route_q, edge_q;
  logic       gen_q;
  logic       nmi_on;
  logic       irq0_n_q, irq1_n_q, nmi_n_q;

  logic       wr, rd;
  logic       wr_pend, wr_mask, wr_route, wr_edge, wr_ctrl;
  logic       rd_vec0, rd_vec1;
  logic [7:0] nmi_sel, edge_eff, rise, clr, edge_fall, edge_next;
  logic [7:0] qual0, qual1;
  logic       v0_valid, v1_valid;
  logic [2:0] v0_idx, v1_idx;

`ifdef IRQ_CTRL_NMI_EN
  logic nmien_q;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      nmien_q <= 1'b0;
    end else if (wr_ctrl) begin
      nmien_q <= DI[CTRL_NMIEN_BIT];
    end
  end

  assign nmi_on = nmien_q;
`else
  assign nmi_on = 1'b0;
`endif

  assign wr       = cs & ~rw;
  assign rd       = cs & rw;
  assign wr_pend  = wr && (AD == REG_PEND);
  assign wr_mask  = wr && (AD == REG_MASK);
  assign wr_route = wr && (AD == REG_ROUTE);
  assign wr_edge  = wr && (AD == REG_EDGE);
  assign wr_ctrl  = wr && (AD == REG_CTRL);
  assign rd_vec0  = rd && (AD == REG_VEC0);
  assign rd_vec1  = rd && (AD == REG_VEC1);

  // With NMI active, source 7 is forced to edge mode and hidden from IRQ routing.
  assign nmi_sel  = nmi_on ? idx_onehot(1'b1, 3'(NMI_SRC)) : 8'h00;
  assign edge_eff = edge_q | nmi_sel;

  assign qual0 = pend_q & mask_q & ~route_q & ~nmi_sel;
  assign qual1 = pend_q & mask_q & route_q & ~nmi_sel;

  irq_prio_enc u_enc0 (
    .req   (qual0),
    .valid (v0_valid),
    .idx   (v0_idx)
  );

  irq_prio_enc u_enc1 (
    .req   (qual1),
    .valid (v1_valid),
    .idx   (v1_idx)
  );

  always_comb begin
    rise      = srcs_q & ~srcs_prev_q;
    clr       = 8'h00;
    edge_fall = 8'h00;
    if (wr_pend) clr = clr | DI;
    if (rd_vec0) clr = clr | idx_onehot(v0_valid, v0_idx);
    if (rd_vec1) clr = clr | idx_onehot(v1_valid, v1_idx);
    if (wr_edge) edge_fall = edge_q & ~DI & ~nmi_sel;
    // A new edge in the same cycle as a clear keeps the bit set.
    edge_next = rise | (pend_q & ~clr);
    pend_d    = (edge_eff & edge_next & ~edge_fall) | (~edge_eff & srcs_q);
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      src_meta_q  <= 8'h00;
      srcs_q      <= 8'h00;
      srcs_prev_q <= 8'h00;
      pend_q      <= 8'h00;
      mask_q      <= 8'h00;
      route_q     <= 8'h00;
      edge_q      <= 8'h00;
      gen_q       <= 1'b0;
    end else begin
      src_meta_q  <= src;
      srcs_q      <= src_meta_q;
      srcs_prev_q <= srcs_q;
      pend_q      <= pend_d;
      if (wr_mask)  mask_q  <= DI;
      if (wr_route) route_q <= DI;
      if (wr_edge)  edge_q  <= DI;
      if (wr_ctrl)  gen_q   <= DI[CTRL_GEN_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      irq0_n_q <= 1'b1;
      irq1_n_q <= 1'b1;
      nmi_n_q  <= 1'b1;
    end else begin
      irq0_n_q <= ~(gen_q & (|qual0));
      irq1_n_q <= ~(gen_q & (|qual1));
      nmi_n_q  <= ~(nmi_on & pend_q[NMI_SRC]);
    end
  end

  assign irq0_n = irq0_n_q;
  assign irq1_n = irq1_n_q;
  assign nmi_n  = nmi_n_q;

  always_comb begin
    DO = 8'h00;
    unique case (AD)
      REG_PEND:  DO = pend_q;
      REG_MASK:  DO = mask_q;
      REG_ROUTE: DO = route_q;
      REG_EDGE:  DO = edge_q;
      REG_VEC0:  DO = vec_byte(v0_valid, v0_idx);
      REG_VEC1:  DO = vec_byte(v1_valid, v1_idx);
      REG_RAW:   DO = srcs_q;
      REG_CTRL: begin
        DO[CTRL_GEN_BIT]   = gen_q;
        DO[CTRL_NMIEN_BIT] = nmi_on;
      end
      default:   DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected read data and pin states,
// a negedge monitor pops and compares whenever a read or a pin probe is presented.
module tb_irq_ctrl;

  logic       clk;
  logic       RESET;
  logic       cs;
  logic       rw;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic [7:0] src;
  logic       irq0_n;
  logic       irq1_n;
  logic       nmi_n;
  logic       probe;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t do_q[$];
  exp_t pin_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  irq_ctrl #(.NSRC(8)) dut (
    .clk    (clk),
    .RESET  (RESET),
    .cs     (cs),
    .rw     (rw),
    .AD     (AD),
    .DI     (DI),
    .DO     (DO),
    .src    (src),
    .irq0_n (irq0_n),
    .irq1_n (irq1_n),
    .nmi_n  (nmi_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples away from the rising edge.
  always @(negedge clk) begin
    if (cs === 1'b1 && rw === 1'b1) begin
      if (do_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got DO=%h, want no read", DO);
      end else begin
        exp_t e;
        e = do_q.pop_front();
        n_checks++;
        if (DO === e.exp) n_pass++;
        else $display("FAIL %s: got DO=%h, want %h", e.name, DO, e.exp);
      end
    end
    if (probe === 1'b1) begin
      logic [7:0] pins;
      pins = {5'b0, nmi_n, irq1_n, irq0_n};
      if (pin_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_probe: got pins=%h, want no probe", pins);
      end else begin
        exp_t e;
        e = pin_q.pop_front();
        n_checks++;
        if (pins === e.exp) n_pass++;
        else $display("FAIL %s: got pins{nmi,irq1,irq0}=%h, want %h", e.name, pins, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    tick();
    cs = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
    do_q.push_back('{n, e});
    cs = 1'b1; rw = 1'b1; AD = a;
    tick();
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic pins(input logic [7:0] e, input string n);
    pin_q.push_back('{n, e});
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; cs = 1'b0; rw = 1'b0; AD = 3'd0; DI = 8'h00; src = 8'h00; probe = 1'b0;
    ticks(3);
    RESET = 1'b1;

    // Reset state
    pins(8'h07, "rst_pins");
    rd(3'd0, 8'h00, "rst_pend");
    rd(3'd1, 8'h00, "rst_mask");
    rd(3'd2, 8'h00, "rst_route");
    rd(3'd3, 8'h00, "rst_edge");
    rd(3'd7, 8'h00, "rst_ctrl");
    rd(3'd4, 8'h00, "rst_vec0");
    rd(3'd6, 8'h00, "rst_raw");

    // Single edge source, 4-clk latency, VEC0 read clears
    wr(3'd3, 8'h01); wr(3'd1, 8'h01); wr(3'd7, 8'h01);
    src = 8'h01; tick(); src = 8'h00;
    ticks(2);
    pins(8'h07, "lat_clk3_high");
    pins(8'h06, "lat_clk4_low");
    rd(3'd4, 8'h80, "vec0_src0");
    rd(3'd0, 8'h00, "pend_after_vec");
    pins(8'h07, "irq0_released");

    // Two sources on two routes
    wr(3'd1, 8'hFF); wr(3'd2, 8'hF0); wr(3'd3, 8'hFF); wr(3'd7, 8'h01);
    src = 8'h24;
    ticks(4);
    pins(8'h04, "both_irq_low");
    rd(3'd0, 8'h24, "pend_two");
    rd(3'd4, 8'h82, "vec0_src2");
    rd(3'd5, 8'h85, "vec1_src5");
    rd(3'd0, 8'h00, "pend_two_cleared");
    src = 8'h00;

    // Level mode ignores clears and tracks srcs
    wr(3'd1, 8'h08); wr(3'd2, 8'h00); wr(3'd3, 8'h00);
    src = 8'h08;
    ticks(4);
    pins(8'h06, "level_irq_low");
    wr(3'd0, 8'h08);
    rd(3'd0, 8'h08, "level_w1c_ignored");
    rd(3'd4, 8'h83, "level_vec0");
    rd(3'd0, 8'h08, "level_vec_ignored");
    src = 8'h00;
    ticks(3);
    pins(8'h06, "level_fall_clk3");
    pins(8'h07, "level_fall_clk4");

    // W1C versus a simultaneous new edge; EDGE 1->0 clears
    wr(3'd1, 8'h02); wr(3'd3, 8'h02);
    src = 8'h02; ticks(3); src = 8'h00;
    wr(3'd0, 8'h02);
    rd(3'd0, 8'h00, "w1c_plain");
    src = 8'h02; ticks(2);
    wr(3'd0, 8'h02);
    rd(3'd0, 8'h02, "set_beats_clear");
    src = 8'h00;
    wr(3'd1, 8'h00); wr(3'd3, 8'h00);
    rd(3'd0, 8'h00, "edge_fall_clears");

`ifdef IRQ_CTRL_NMI_EN
    wr(3'd7, 8'h03);
    rd(3'd7, 8'h03, "ctrl_nmien");
    wr(3'd1, 8'h80);
    src = 8'h80;
    ticks(4);
    pins(8'h03, "nmi_low");
    rd(3'd4, 8'h00, "nmi_vec0_excluded");
    rd(3'd0, 8'h80, "nmi_pend");
    wr(3'd0, 8'h80);
    pins(8'h03, "nmi_still_low");
    pins(8'h07, "nmi_released");
    src = 8'h00;
    wr(3'd1, 8'h00); wr(3'd7, 8'h01);
`else
    wr(3'd7, 8'h03);
    rd(3'd7, 8'h01, "ctrl_nmien_absent");
    wr(3'd1, 8'h80);
    src = 8'h80;
    ticks(4);
    pins(8'h06, "src7_plain_irq");
    src = 8'h00;
    wr(3'd1, 8'h00);
`endif

    // Reset during a MASK write leaves no trace
    ticks(3);
    RESET = 1'b0; cs = 1'b1; rw = 1'b0; AD = 3'd1; DI = 8'hFF;
    tick();
    cs = 1'b0; RESET = 1'b1;
    rd(3'd1, 8'h00, "mid_reset_mask");
    rd(3'd7, 8'h00, "mid_reset_ctrl");
    pins(8'h07, "mid_reset_pins");

    ticks(2);
    if (do_q.size() != 0 || pin_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover_expectations: got %0d pending, want 0",
               do_q.size() + pin_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
